// File: rtl/resp_checker_pkg.sv
// Shared types and golden function for the gate-delay response checkers.
package resp_checker_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    // Expected {x, y} for vector {A,B,C}: x = (A|B)&~C, y = ~C
    function automatic logic [1:0] exp_xy(input logic [2:0] v);
        return {(v[2] | v[1]) & ~v[0], ~v[0]};
    endfunction

endpackage

// File: rtl/golden_xy.sv
// Combinational golden model of the checked circuit, shared across lab checkers.
module golden_xy
    import resp_checker_pkg::*;
(
    input  logic [2:0] vec_q,
    output logic       x_exp,
    output logic       y_exp
);

    assign {x_exp, y_exp} = exp_xy(vec_q);

endmodule

// File: rtl/resp_checker.sv
// Accepts vectors by valid/ready, waits a settle time, samples x/y against the
// golden model, and reports mismatch count, first failing vector and pass/fail.
module resp_checker
    import resp_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NUM_VEC       = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [2:0]       vec,
    input  logic             x_in,
    input  logic             y_in,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_fail_valid,
    output logic [2:0]       first_fail_vec,
    output logic             done,
    output logic             pass
);

    localparam int unsigned SC_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned IDX_W   = $clog2(NUM_VEC + 1);
    localparam int unsigned SC_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [2:0]         vec_q, vec_d;
    logic [SC_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               ff_valid_q, ff_valid_d;
    logic [2:0]         ff_vec_q, ff_vec_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               vec_ready_q, vec_ready_d;
    logic               x_exp, y_exp;
    logic               mismatch_c;

    golden_xy u_golden (
        .vec_q (vec_q),
        .x_exp (x_exp),
        .y_exp (y_exp)
    );

    assign mismatch_c = (x_in != x_exp) || (y_in != y_exp);

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_cnt_d = settle_cnt_q;
        vec_idx_d    = vec_idx_q;
        err_cnt_d    = err_cnt_q;
        ff_valid_d   = ff_valid_q;
        ff_vec_d     = ff_vec_q;
        done_d       = done_q;
        pass_d       = pass_q;

        case (state_q)
            IDLE: begin
                if (vec_valid && vec_ready_q) begin
                    vec_d = vec;
                    if (SETTLE_CYCLES > 0) begin
                        settle_cnt_d = SC_W'(SC_LOAD);
                        state_d      = SETTLE;
                    end else begin
                        state_d = SAMPLE;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q - SC_W'(1);
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = vec_q;
                    end
                end
                vec_idx_d = vec_idx_q + IDX_W'(1);
                if (vec_idx_q == IDX_W'(NUM_VEC - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is a pure decode of the registered state
        vec_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            settle_cnt_q <= '0;
            vec_idx_q    <= '0;
            err_cnt_q    <= '0;
            ff_valid_q   <= 1'b0;
            ff_vec_q     <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            vec_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_cnt_q <= settle_cnt_d;
            vec_idx_q    <= vec_idx_d;
            err_cnt_q    <= err_cnt_d;
            ff_valid_q   <= ff_valid_d;
            ff_vec_q     <= ff_vec_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            vec_ready_q  <= vec_ready_d;
        end
    end

    assign vec_ready        = vec_ready_q;
    assign err_cnt          = err_cnt_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;
    assign done             = done_q;
    assign pass             = pass_q;

endmodule

// File: tb/tb_resp_checker.sv
// Bench for resp_checker: two configurations (default, and zero settle with a 2-bit counter)
// checked every cycle against a transaction-timeline model, plus literal end-of-run checks.
module tb_resp_checker;

    localparam int S0 = 4;
    localparam int S1 = 0;
    localparam int NV = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       vv[2];
    logic [2:0] vc[2];
    logic       xi[2], yi[2];
    logic       rdy[2], ffv[2], dn[2], ps[2];
    logic [2:0] ffvec[2];
    logic [7:0] ec0;
    logic [1:0] ec1;

    // circuit emulation: mode 0 correct, 1 x stuck at 1, 2 both inverted, 3 random bits
    logic [2:0] applied[2];
    int         mode[2];
    logic       rx[2], ry[2];

    int n_vec  = 0;
    int n_chk  = 0;
    int n_fail = 0;

    resp_checker #(.SETTLE_CYCLES(S0), .NUM_VEC(NV), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .vec_valid(vv[0]), .vec_ready(rdy[0]), .vec(vc[0]),
        .x_in(xi[0]), .y_in(yi[0]), .err_cnt(ec0), .first_fail_valid(ffv[0]),
        .first_fail_vec(ffvec[0]), .done(dn[0]), .pass(ps[0])
    );

    resp_checker #(.SETTLE_CYCLES(S1), .NUM_VEC(NV), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .vec_valid(vv[1]), .vec_ready(rdy[1]), .vec(vc[1]),
        .x_in(xi[1]), .y_in(yi[1]), .err_cnt(ec1), .first_fail_valid(ffv[1]),
        .first_fail_vec(ffvec[1]), .done(dn[1]), .pass(ps[1])
    );

    // Truth-table form of the reference circuit: x high for 010,100,110; y high for even vectors
    function automatic logic [1:0] golden(input logic [2:0] v);
        logic xg, yg;
        xg = (v == 3'd2) || (v == 3'd4) || (v == 3'd6);
        yg = (v[0] == 1'b0);
        return {xg, yg};
    endfunction

    function automatic logic [1:0] circ_out(input logic [2:0] v, input int md, input logic a, input logic b);
        logic [1:0] g;
        g = golden(v);
        case (md)
            1:       return {1'b1, g[0]};
            2:       return ~g;
            3:       return {a, b};
            default: return g;
        endcase
    endfunction

    assign {xi[0], yi[0]} = circ_out(applied[0], mode[0], rx[0], ry[0]);
    assign {xi[1], yi[1]} = circ_out(applied[1], mode[1], rx[1], ry[1]);

    function automatic int settle_of(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 255 : 3;
    endfunction

    // Transaction-timeline model: a vector accepted at edge e is judged at edge e+S+1
    int         cyc = 0;
    bit         m_busy[2], m_done[2], m_ffv[2];
    int         m_acc[2], m_err[2], m_k[2];
    logic [2:0] m_vec[2], m_ffvec[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_done[i] = 0; m_ffv[i] = 0;
                m_acc[i] = 0; m_err[i] = 0; m_k[i] = 0;
                m_vec[i] = '0; m_ffvec[i] = '0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i] && cyc == m_acc[i] + settle_of(i) + 1) begin
                    if ({xi[i], yi[i]} != golden(m_vec[i])) begin
                        if (m_err[i] < max_of(i)) m_err[i]++;
                        if (!m_ffv[i]) begin
                            m_ffv[i] = 1;
                            m_ffvec[i] = m_vec[i];
                        end
                    end
                    m_busy[i] = 0;
                    m_k[i]++;
                    if (m_k[i] == NV) m_done[i] = 1;
                end else if (!m_busy[i] && !m_done[i] && vv[i]) begin
                    m_busy[i] = 1;
                    m_acc[i]  = cyc;
                    m_vec[i]  = vc[i];
                    n_vec++;
                end
            end
        end
    end

    task automatic check(input string name, input int i, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    function automatic int err_of(input int i);
        return (i == 0) ? int'(ec0) : int'(ec1);
    endfunction

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check("vec_ready", i, int'(rdy[i]), int'(!m_busy[i] && !m_done[i]));
            check("err_cnt", i, err_of(i), m_err[i]);
            check("first_fail_valid", i, int'(ffv[i]), int'(m_ffv[i]));
            check("first_fail_vec", i, int'(ffvec[i]), int'(m_ffvec[i]));
            check("done", i, int'(dn[i]), int'(m_done[i]));
            check("pass", i, int'(ps[i]), int'(m_done[i] && m_err[i] == 0));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vv[0] = 1'b0; vv[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents NV vectors on instance i; md 4 picks a random circuit mode per vector.
    task automatic drive(input int i, input logic [2:0] seq[NV], input int md, input bit gaps,
                         input bit toggle, input int abort_at, output longint hs_t);
        hs_t = -1;
        for (int k = 0; k < NV; k++) begin
            bit taken = 0;
            int budget = 0;
            while (!taken) begin
                @(negedge clk);
                if (rdy[i]) begin
                    if (gaps && $urandom_range(0, 2) == 0) begin
                        vv[i] = 1'b0;
                        vc[i] = 3'($urandom);
                    end else begin
                        vv[i] = 1'b1;
                        vc[i] = seq[k];
                        applied[i] = seq[k];
                        mode[i] = (md == 4) ? (($urandom_range(0, 1) == 0) ? 0 : 3) : md;
                        rx[i] = 1'($urandom);
                        ry[i] = 1'($urandom);
                        if (hs_t < 0) hs_t = longint'($time);
                        taken = 1;
                    end
                end else begin
                    vv[i] = gaps ? 1'($urandom) : 1'b1;
                    if (toggle) vc[i] = 3'($urandom);
                end
                budget++;
                if (!taken && budget > 100) begin
                    check("handshake_timeout", i, 0, 1);
                    vv[i] = 1'b0;
                    return;
                end
            end
            if (k == abort_at) begin
                @(posedge clk);
                #12;
                check("pre_reset_err", i, err_of(i), 2);
                rst = 1'b1;
                vv[i] = 1'b0;
                #1;
                check("async_rst_ready", i, int'(rdy[i]), 1);
                check("async_rst_err", i, err_of(i), 0);
                check("async_rst_ffv", i, int'(ffv[i]), 0);
                check("async_rst_ffvec", i, int'(ffvec[i]), 0);
                check("async_rst_done", i, int'(dn[i]), 0);
                check("async_rst_pass", i, int'(ps[i]), 0);
                return;
            end
        end
        @(negedge clk);
        vv[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output longint t_done);
        int budget = 0;
        t_done = -1;
        while (!dn[i]) begin
            @(negedge clk);
            budget++;
            if (budget > 300) begin
                check("done_timeout", i, 0, 1);
                return;
            end
        end
        t_done = longint'($time);
    endtask

    initial begin
        logic [2:0] seq[NV];
        logic [2:0] ord[NV];
        longint     t_hs, t_dn;

        for (int i = 0; i < 2; i++) begin
            vv[i] = 1'b0; vc[i] = '0; applied[i] = '0; mode[i] = 0; rx[i] = 1'b0; ry[i] = 1'b0;
        end
        for (int k = 0; k < NV; k++) ord[k] = 3'(k);

        #1 rst = 1'b1;
        #12;
        check("reset_ready", 0, int'(rdy[0]), 1);
        check("reset_err", 0, int'(ec0), 0);
        check("reset_done", 0, int'(dn[0]), 0);
        check("reset_pass", 0, int'(ps[0]), 0);
        @(negedge clk);
        rst = 1'b0;

        // clean back-to-back run, default settle
        drive(0, ord, 0, 0, 0, -1, t_hs);
        wait_done(0, t_dn);
        check("done_latency", 0, int'((t_dn - t_hs) / 10), 48);
        check("clean_pass", 0, int'(ps[0]), 1);
        check("clean_err", 0, int'(ec0), 0);
        check("clean_ffv", 0, int'(ffv[0]), 0);

        // x stuck at 1
        do_reset();
        drive(0, ord, 1, 0, 0, -1, t_hs);
        wait_done(0, t_dn);
        check("xstuck_err", 0, int'(ec0), 5);
        check("xstuck_ffv", 0, int'(ffv[0]), 1);
        check("xstuck_ffvec", 0, int'(ffvec[0]), 0);
        check("xstuck_done", 0, int'(dn[0]), 1);
        check("xstuck_pass", 0, int'(ps[0]), 0);

        // zero settle: 2 cycles per vector
        do_reset();
        drive(1, ord, 0, 0, 0, -1, t_hs);
        wait_done(1, t_dn);
        check("s0_latency", 1, int'((t_dn - t_hs) / 10), 16);
        check("s0_pass", 1, int'(ps[1]), 1);

        // saturation of a 2-bit counter
        do_reset();
        drive(1, ord, 2, 0, 0, -1, t_hs);
        wait_done(1, t_dn);
        check("sat_err", 1, int'(ec1), 3);
        check("sat_pass", 1, int'(ps[1]), 0);
        check("sat_ffvec", 1, int'(ffvec[1]), 0);

        // vec toggling while busy, then valid held in DONE
        do_reset();
        drive(0, ord, 0, 0, 1, -1, t_hs);
        wait_done(0, t_dn);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vv[0] = 1'b1;
            vc[0] = 3'($urandom);
        end
        @(negedge clk);
        vv[0] = 1'b0;
        check("toggle_err", 0, int'(ec0), 0);
        check("done_ready", 0, int'(rdy[0]), 0);
        check("toggle_pass", 0, int'(ps[0]), 1);

        // reset during settle of the 4th vector, then a fresh clean run
        do_reset();
        drive(0, ord, 1, 0, 0, 3, t_hs);
        @(negedge clk);
        rst = 1'b0;
        drive(0, ord, 0, 0, 0, -1, t_hs);
        wait_done(0, t_dn);
        check("rerun_pass", 0, int'(ps[0]), 1);
        check("rerun_err", 0, int'(ec0), 0);

        // randomized runs on both configurations
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 2; i++) begin
                do_reset();
                for (int k = 0; k < NV; k++) seq[k] = 3'($urandom);
                drive(i, seq, 4, 1'($urandom), 1'($urandom), -1, t_hs);
                wait_done(i, t_dn);
                repeat (3) @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/resp_checker.md
# resp_checker

Synthesizable response checker forming the receiving end of the gate-delay stimulus flow. A stimulus source presents 3-bit input vectors {A,B,C} through a valid/ready handshake. For each accepted vector the block waits a programmable settle time for the delayed circuit outputs to stabilise, then samples x and y. The samples are compared against the golden function x = (A|B)&~C, y = ~C. Mismatches are counted and the first failing vector is recorded, and the block reports pass or fail after NUM_VEC vectors.

## Interface
- SETTLE_CYCLES, 4: clk cycles waited after vector acceptance before sampling; 0 is legal.
- NUM_VEC, 8: vectors per run, range 1..256.
- CNT_W, 8: mismatch counter width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- vec_valid  input  1  source has a vector on vec.
- vec_ready  output  1  checker can accept a vector.
- vec  input  3  applied vector {A,B,C}, with A as the MSB.
- x_in  input  1  circuit output x, synchronous to clk.
- y_in  input  1  circuit output y, synchronous to clk.
- err_cnt  output  CNT_W  mismatching vectors so far; saturates.
- first_fail_valid  output  1  at least one mismatch recorded.
- first_fail_vec  output  3  vector of the first mismatch.
- done  output  1  run complete.
- pass  output  1  done and err_cnt==0.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: vec_ready=1. When vec_valid&&vec_ready is true at an edge, latch vec into vec_q.
  - If SETTLE_CYCLES>0: load settle_cnt=SETTLE_CYCLES-1 and go to SETTLE.
  - If SETTLE_CYCLES==0: go to SAMPLE.
- SETTLE: vec_ready=0. Decrement settle_cnt each cycle. When settle_cnt==0, go to SAMPLE.
- SAMPLE: one cycle, vec_ready=0. At the edge, compare {x_in,y_in} with exp_xy(vec_q).
  - On mismatch, err_cnt increments, saturating at 2^CNT_W-1.
  - On mismatch with first_fail_valid==0: set first_fail_valid=1 and first_fail_vec=vec_q.
  - vec_idx increments. If vec_idx==NUM_VEC-1 before the increment, go to DONE; otherwise go to IDLE.
- DONE: terminal state. done=1, vec_ready=0, pass=(err_cnt==0), and vec_valid is ignored. Only rst leaves DONE.
- vec changes while vec_ready==0 are ignored. vec_q holds the accepted vector.
- Both a mismatch on x alone and a mismatch on y alone count as one error per vector.
- Reset values: state=IDLE, vec_ready=1, err_cnt=0, first_fail_valid=0, first_fail_vec=0, done=0, pass=0, vec_idx=0, settle_cnt=0.
- Reset mid-run, in any state, aborts immediately to the reset values. No partial results are retained.

## Timing
- Handshake edge T: the vector is accepted.
- Sampling edge: T+SETTLE_CYCLES+1.
- err_cnt and first_fail_* update at the sampling edge and are visible in the following cycle.
- vec_ready returns high in the cycle after the sampling edge.
- Per-vector throughput is SETTLE_CYCLES+2 cycles when vec_valid is held high.
- done and pass assert in the cycle after the last sampling edge.
- vec_ready is a registered-state decode (a function of state only). It never depends combinationally on vec_valid.
- Settle time bound: the integrator must choose SETTLE_CYCLES×Tclk ≥ the worst-case combinational path delay of the checked circuit. For the gate-level model this is 50 time units (OR 30 + AND 20).

## Structure
- Package resp_checker_pkg:
  - state_t enum {IDLE, SETTLE, SAMPLE, DONE}.
  - Function exp_xy(input [2:0] v), returning {(v[2]|v[1])&~v[0], ~v[0]}.
- Sub-module golden_xy: combinational golden model, vec_q in, {x_exp,y_exp} out, built on exp_xy. It is reused by other checkers in the lab.
- settle_cnt width is $clog2(SETTLE_CYCLES+1), with a minimum of 1. vec_idx width is $clog2(NUM_VEC+1).

## Test plan
- Connect a correct golden DUT and drive all 8 vectors 000..111 back-to-back with defaults. Required: done asserts 8×6=48 cycles after the first acceptance, with pass=1, err_cnt=0 and first_fail_valid=0.
- Force x_in=1 on all vectors. Required: mismatches on vectors 000, 001, 011, 101, 111, so err_cnt=5; first_fail_valid=1, first_fail_vec=000; done=1, pass=0.
- Run with SETTLE_CYCLES=0. Required: the sample occurs at the edge after acceptance, vec_ready toggles 1,0,1 and throughput is 2 cycles per vector; a correct DUT gives pass=1.
- Toggle vec between edges while in SETTLE, and assert vec_valid in DONE. Required: no effect on vec_q or err_cnt; vec_ready stays 0 in DONE.
- Run with CNT_W=2 and every vector failing. Required: err_cnt saturates at 3 and does not wrap.
- Assert rst during SETTLE of the 4th vector, then run 8 clean vectors. Required: all outputs return to reset values asynchronously, followed by a full fresh run ending with pass=1 and err_cnt=0.
